// File: rtl/befehls_abruf.sv
// Instruction fetch stage: holds the PC, fetches one word per request/ready
// handshake, presents it to the decoder and waits for release via Weiter.
module befehls_abruf #(
  parameter logic [31:0] START_ADRESSE  = 32'h0000_0000,
  parameter logic [31:0] ADRESS_SCHRITT = 32'd1,
  parameter logic [15:0] WARTE_LIMIT    = 16'd255
) (
  input  logic        Takt,
  input  logic        Reset,
  output logic [31:0] SpeicherAdresse,
  output logic        SpeicherLesen,
  input  logic        SpeicherBereit,
  input  logic [31:0] SpeicherDaten,
  output logic [31:0] Instruktion,
  output logic        DekodierSignal,
  output logic [31:0] ProgrammZaehler,
  input  logic        Weiter,
  input  logic        SprungAktiv,
  input  logic [31:0] SprungZiel,
  output logic        Fehler,
  output logic [1:0]  Zustand
);

  // Handshake: a memory word is taken on every rising edge where
  // SpeicherLesen=1 and SpeicherBereit=1; SpeicherLesen stays high until then.
  // The downstream release is taken on every edge in AUSGABE with Weiter=1.

  typedef enum logic [1:0] {START, ANFRAGE, AUSGABE, FEHLER} zustand_t;

  zustand_t    zustand;
  zustand_t    folgeZustand;
  logic [31:0] pc;
  logic [15:0] warteZaehler;
  logic        annehmen;
  logic        zeitAus;
  logic        freigabe;

  assign annehmen = (zustand == ANFRAGE) && SpeicherBereit;
  assign freigabe = (zustand == AUSGABE) && Weiter;
  // Ready on the limit edge wins over the timeout.
  assign zeitAus  = (zustand == ANFRAGE) && !SpeicherBereit &&
                    (WARTE_LIMIT != 16'd0) &&
                    (warteZaehler == WARTE_LIMIT - 16'd1);

  always_comb begin
    folgeZustand = zustand;
    case (zustand)
      START:   folgeZustand = ANFRAGE;
      ANFRAGE: begin
        if (annehmen)     folgeZustand = AUSGABE;
        else if (zeitAus) folgeZustand = FEHLER;
      end
      AUSGABE: if (freigabe) folgeZustand = ANFRAGE;
      FEHLER:  folgeZustand = FEHLER;
      default: folgeZustand = START;
    endcase
  end

  always_ff @(posedge Takt or posedge Reset) begin
    if (Reset) zustand <= START;
    else       zustand <= folgeZustand;
  end

  always_ff @(posedge Takt or posedge Reset) begin
    if (Reset) begin
      pc              <= START_ADRESSE;
      warteZaehler    <= 16'd0;
      Instruktion     <= 32'h0;
      ProgrammZaehler <= START_ADRESSE;
      DekodierSignal  <= 1'b0;
    end else begin
      DekodierSignal <= annehmen;
      // Counter is zero whenever a fresh request starts.
      if ((zustand == ANFRAGE) && !SpeicherBereit) warteZaehler <= warteZaehler + 16'd1;
      else                                          warteZaehler <= 16'd0;
      if (annehmen) begin
        Instruktion     <= SpeicherDaten;
        ProgrammZaehler <= pc;
      end
      if (freigabe) pc <= SprungAktiv ? SprungZiel : pc + ADRESS_SCHRITT;
    end
  end

  assign SpeicherAdresse = pc;
  assign SpeicherLesen   = (zustand == ANFRAGE);
  assign Fehler          = (zustand == FEHLER);
  assign Zustand         = zustand;

endmodule

// File: tb/tb_befehls_abruf.sv
// Bench for befehls_abruf: vector table for the main fetch/jump flow, plus
// hand sequences for hold, reset, PC wrap and memory timeout.
module tb_befehls_abruf;

  logic Takt = 1'b0;
  always #5 Takt = ~Takt;

  // dut0: default parameters
  logic        Reset0, Lesen0, Bereit0, Dek0, Weiter0, Sprung0, Fehler0;
  logic [31:0] Adresse0, Daten0, Instr0, Pz0, Ziel0;
  logic [1:0]  Zustand0;
  // dut1: wrap start address and short timeout
  logic        Reset1, Lesen1, Bereit1, Dek1, Weiter1, Sprung1, Fehler1;
  logic [31:0] Adresse1, Daten1, Instr1, Pz1, Ziel1;
  logic [1:0]  Zustand1;

  befehls_abruf dut0 (
    .Takt(Takt), .Reset(Reset0), .SpeicherAdresse(Adresse0), .SpeicherLesen(Lesen0),
    .SpeicherBereit(Bereit0), .SpeicherDaten(Daten0), .Instruktion(Instr0),
    .DekodierSignal(Dek0), .ProgrammZaehler(Pz0), .Weiter(Weiter0),
    .SprungAktiv(Sprung0), .SprungZiel(Ziel0), .Fehler(Fehler0), .Zustand(Zustand0)
  );

  befehls_abruf #(.START_ADRESSE(32'hFFFF_FFFF), .ADRESS_SCHRITT(32'd1), .WARTE_LIMIT(16'd4)) dut1 (
    .Takt(Takt), .Reset(Reset1), .SpeicherAdresse(Adresse1), .SpeicherLesen(Lesen1),
    .SpeicherBereit(Bereit1), .SpeicherDaten(Daten1), .Instruktion(Instr1),
    .DekodierSignal(Dek1), .ProgrammZaehler(Pz1), .Weiter(Weiter1),
    .SprungAktiv(Sprung1), .SprungZiel(Ziel1), .Fehler(Fehler1), .Zustand(Zustand1)
  );

  typedef struct {
    logic        bereit;
    logic [31:0] daten;
    logic        weiter;
    logic        sprung;
    logic [31:0] ziel;
    logic        lesen;
    logic [31:0] adresse;
    logic        dek;
    logic [31:0] instr;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] A1 = 32'hA000_0001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic b, input logic [31:0] d, input logic w, input logic s,
                     input logic [31:0] z, input logic l, input logic [31:0] a,
                     input logic k, input logic [31:0] i, input logic [31:0] p);
    vec_t v;
    v.bereit = b; v.daten = d; v.weiter = w; v.sprung = s; v.ziel = z;
    v.lesen = l; v.adresse = a; v.dek = k; v.instr = i; v.pc = p;
    vecs.push_back(v);
  endtask

  task automatic chk0(input string tag, input logic l, input logic [31:0] a,
                      input logic k, input logic [31:0] i, input logic [31:0] p);
    chk({tag, " lesen"}, {31'd0, Lesen0}, {31'd0, l});
    chk({tag, " adresse"}, Adresse0, a);
    chk({tag, " dekodier"}, {31'd0, Dek0}, {31'd0, k});
    chk({tag, " instruktion"}, Instr0, i);
    chk({tag, " pz"}, Pz0, p);
    chk({tag, " fehler"}, {31'd0, Fehler0}, 32'd0);
  endtask

  initial begin
    Reset0 = 1'b1; Bereit0 = 1'b0; Daten0 = '0; Weiter0 = 1'b0; Sprung0 = 1'b0; Ziel0 = '0;
    Reset1 = 1'b1; Bereit1 = 1'b0; Daten1 = '0; Weiter1 = 1'b0; Sprung1 = 1'b0; Ziel1 = '0;

    //  bereit daten         w  s  ziel     | lesen adresse dek instr          pc
    add(1, A1,             1, 0, 32'h0,   0, 32'h0,  0, 32'h0,         32'h0);  // START
    add(1, A1,             1, 0, 32'h0,   1, 32'h0,  0, 32'h0,         32'h0);
    add(1, A1,             1, 0, 32'h0,   0, 32'h0,  1, A1,            32'h0);
    add(1, A1,             1, 0, 32'h0,   1, 32'h1,  0, A1,            32'h0);
    add(1, A1,             1, 0, 32'h0,   0, 32'h1,  1, A1,            32'h1);
    add(1, A1,             1, 0, 32'h0,   1, 32'h2,  0, A1,            32'h1);
    add(1, A1,             1, 0, 32'h0,   0, 32'h2,  1, A1,            32'h2);
    add(1, 32'h3333_3333,  1, 1, 32'h80,  1, 32'h3,  0, A1,            32'h2);  // jump ignored in ANFRAGE
    add(1, 32'h0,          1, 0, 32'h0,   0, 32'h3,  1, 32'h3333_3333, 32'h3);
    add(1, 32'h4444_4444,  1, 0, 32'h0,   1, 32'h4,  0, 32'h3333_3333, 32'h3);
    add(0, 32'h0,          1, 0, 32'h0,   0, 32'h4,  1, 32'h4444_4444, 32'h4);
    add(0, 32'hDEAD_BEEF,  1, 1, 32'h80,  1, 32'h5,  0, 32'h4444_4444, 32'h4);  // wait cycle
    add(1, 32'h5555_5555,  1, 0, 32'h0,   1, 32'h5,  0, 32'h4444_4444, 32'h4);
    add(1, 32'h0,          1, 1, 32'h40,  0, 32'h5,  1, 32'h5555_5555, 32'h5);  // jump to 0x40
    add(1, 32'h6666_6666,  0, 0, 32'h0,   1, 32'h40, 0, 32'h5555_5555, 32'h5);
    add(1, 32'h0,          0, 1, 32'h99,  0, 32'h40, 1, 32'h6666_6666, 32'h40);
    add(1, 32'h0,          0, 0, 32'h0,   0, 32'h40, 0, 32'h6666_6666, 32'h40);

    repeat (2) @(posedge Takt);
    @(negedge Takt);
    chk0("reset0", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    Reset0 = 1'b0;

    // Table: each row drives this cycle's inputs and checks this cycle's outputs.
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge Takt);
      Bereit0 = vecs[i].bereit; Daten0 = vecs[i].daten; Weiter0 = vecs[i].weiter;
      Sprung0 = vecs[i].sprung; Ziel0 = vecs[i].ziel;
      chk0($sformatf("vec%0d", i), vecs[i].lesen, vecs[i].adresse, vecs[i].dek,
           vecs[i].instr, vecs[i].pc);
    end

    // Weiter held low: word stays put, no new request.
    for (int c = 0; c < 20; c++) begin
      @(negedge Takt);
      Bereit0 = 1'b1; Daten0 = $urandom;
      chk0("hold", 1'b0, 32'h40, 1'b0, 32'h6666_6666, 32'h40);
    end

    Weiter0 = 1'b1; Bereit0 = 1'b0;
    @(negedge Takt);
    Weiter0 = 1'b0;
    chk0("release", 1'b1, 32'h41, 1'b0, 32'h6666_6666, 32'h40);

    // Reset during ANFRAGE with a pending ready response.
    @(negedge Takt);
    Bereit0 = 1'b1; Daten0 = 32'h7777_7777;
    chk0("pre_reset", 1'b1, 32'h41, 1'b0, 32'h6666_6666, 32'h40);
    Reset0 = 1'b1;
    #1;
    chk0("async_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge Takt);
    Reset0 = 1'b0;
    chk0("after_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge Takt);
    Bereit0 = 1'b0;
    chk0("restart", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // dut1: wrap of PC from FFFF_FFFF to 0.
    @(negedge Takt);
    Reset1 = 1'b0;
    chk("wrap start lesen", {31'd0, Lesen1}, 32'd0);
    @(negedge Takt);
    chk("wrap first adresse", Adresse1, 32'hFFFF_FFFF);
    Bereit1 = 1'b1; Daten1 = 32'h1111_1111;
    @(negedge Takt);
    Bereit1 = 1'b0; Weiter1 = 1'b1;
    chk("wrap pz", Pz1, 32'hFFFF_FFFF);
    chk("wrap instr", Instr1, 32'h1111_1111);
    @(negedge Takt);
    Weiter1 = 1'b0;
    chk("wrap second adresse", Adresse1, 32'h0);

    // Ready on the 4th request cycle: success, not fault.
    for (int c = 0; c < 3; c++) begin
      chk("limit lesen", {31'd0, Lesen1}, 32'd1);
      @(negedge Takt);
    end
    chk("limit lesen4", {31'd0, Lesen1}, 32'd1);
    Bereit1 = 1'b1; Daten1 = 32'h2222_2222;
    @(negedge Takt);
    Bereit1 = 1'b0;
    chk("limit fehler", {31'd0, Fehler1}, 32'd0);
    chk("limit dek", {31'd0, Dek1}, 32'd1);
    chk("limit instr", Instr1, 32'h2222_2222);
    chk("limit pz", Pz1, 32'h0);
    Weiter1 = 1'b1;
    @(negedge Takt);
    Weiter1 = 1'b0;
    chk("timeout adresse", Adresse1, 32'h1);

    // Four request cycles without ready: fault.
    repeat (3) @(negedge Takt);
    chk("timeout pre fehler", {31'd0, Fehler1}, 32'd0);
    chk("timeout pre lesen", {31'd0, Lesen1}, 32'd1);
    @(negedge Takt);
    Bereit1 = 1'b1; Weiter1 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("timeout fehler", {31'd0, Fehler1}, 32'd1);
      chk("timeout lesen", {31'd0, Lesen1}, 32'd0);
      @(negedge Takt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
